// File: rtl/trig_stream_pkg.sv
// Shared widths and word type for the trigger stream buffer slice.
package trig_stream_pkg;
  localparam int TRIG_WORD_W = 32;
  localparam int DROP_CNT_W  = 16;
  localparam int STAT_CNT_W  = 32;

  typedef logic [TRIG_WORD_W-1:0] trig_word_t;
endpackage

// File: rtl/trig_fifo_fwft.sv
// First-word-fall-through FIFO, 2^DEPTH_LOG2 words; a word pushed at edge N is at the head after edge N.
// No internal backpressure: the caller gates push/pop; flush_i empties it and discards that cycle's push/pop.
module trig_fifo_fwft
  import trig_stream_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_WIDTH = TRIG_WORD_W
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic [DEPTH_LOG2:0]   count_next_o,
  output logic                  empty_o,
  output logic                  full_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rstn_i && !flush_i && push_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o    = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign empty_o      = (count_q == '0);
  assign full_o       = (count_q == DEPTH_CNT);
endmodule

// File: rtl/trig_stream_buffer.sv
// Trigger-word FWFT buffer with drop/backpressure policy and housekeeping stats; 1-cycle latency.
// Backpressure: DROP_ON_FULL="TRUE" never stalls (drops+counts), "FALSE" stalls via s_trig_tready; TRIG_STREAM_BUFFER_STATS_EN adds counters.
module trig_stream_buffer
  import trig_stream_pkg::*;
#(
  parameter int    DEPTH_LOG2   = 4,
  parameter string DROP_ON_FULL = "TRUE",
  parameter int    DATA_WIDTH   = TRIG_WORD_W
) (
  input  logic                  ifclk,
  input  logic                  ifclk_rstn_i,
  input  logic                  runrst_i,
  input  logic [DATA_WIDTH-1:0] s_trig_tdata,
  input  logic                  s_trig_tvalid,
  output logic                  s_trig_tready,
  output logic [DATA_WIDTH-1:0] m_trig_tdata,
  output logic                  m_trig_tvalid,
  input  logic                  m_trig_tready,
  output logic [DEPTH_LOG2:0]   occupancy_o,
  output logic [DEPTH_LOG2:0]   high_water_o,
  output logic [DROP_CNT_W-1:0] dropped_o,
  output logic                  overflow_o
`ifdef TRIG_STREAM_BUFFER_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] accepted_o,
  output logic [STAT_CNT_W-1:0] stall_cycles_o
`endif
);
  localparam bit DROP_MODE = (DROP_ON_FULL == "TRUE");
  localparam int CNT_W     = DEPTH_LOG2 + 1;

  logic [CNT_W-1:0]      count, count_next;
  logic                  fifo_empty, fifo_full;
  logic                  push, pop, drop;
  logic [CNT_W-1:0]      high_water_q, high_water_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;
  logic                  overflow_q, overflow_d;

  trig_fifo_fwft #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk          (ifclk),
    .rstn_i       (ifclk_rstn_i),
    .flush_i      (runrst_i),
    .push_i       (push),
    .pop_i        (pop),
    .wr_data_i    (s_trig_tdata),
    .rd_data_o    (m_trig_tdata),
    .count_o      (count),
    .count_next_o (count_next),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full)
  );

  // Ready depends only on registered state, so a full FIFO refuses even when it pops this cycle.
  always_comb begin
    s_trig_tready = DROP_MODE || !fifo_full;
    m_trig_tvalid = !fifo_empty;
    pop           = m_trig_tvalid && m_trig_tready;
    push          = s_trig_tvalid && s_trig_tready && (!fifo_full || pop);
    drop          = DROP_MODE && s_trig_tvalid && fifo_full && !pop;

    high_water_d = (count_next > high_water_q) ? count_next : high_water_q;
    dropped_d    = dropped_q;
    if (drop && (dropped_q != '1)) dropped_d = dropped_q + 1'b1;
    overflow_d   = drop;

    if (runrst_i) begin
      high_water_d = '0;
      dropped_d    = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge ifclk) begin
    if (!ifclk_rstn_i) begin
      high_water_q <= '0;
      dropped_q    <= '0;
      overflow_q   <= 1'b0;
    end else begin
      high_water_q <= high_water_d;
      dropped_q    <= dropped_d;
      overflow_q   <= overflow_d;
    end
  end

  assign occupancy_o  = count;
  assign high_water_o = high_water_q;
  assign dropped_o    = dropped_q;
  assign overflow_o   = overflow_q;

`ifdef TRIG_STREAM_BUFFER_STATS_EN
  logic [STAT_CNT_W-1:0] accepted_q, accepted_d;
  logic [STAT_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    accepted_d     = accepted_q;
    stall_cycles_d = stall_cycles_q;
    if (push) accepted_d = accepted_q + 1'b1;
    if (m_trig_tvalid && !m_trig_tready && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (runrst_i) begin
      accepted_d     = '0;
      stall_cycles_d = '0;
    end
  end

  always_ff @(posedge ifclk) begin
    if (!ifclk_rstn_i) begin
      accepted_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      accepted_q     <= accepted_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign accepted_o     = accepted_q;
  assign stall_cycles_o = stall_cycles_q;
`endif
endmodule
